bg_line_scheduler: RTL
======================

# bg_line_scheduler

Sequences reads of the 240×180 8-bit background image from a synchronous ROM into a ping-pong pair of line buffers, one VGA line ahead of display. Sits between the background image ROM and the VGA pixel mux: it replaces per-pixel combinational ROM indexing with a scheduled burst fetch per source row. Each source row is fetched once and reused across the VGA lines that map to it. The current displayed row is served from the front buffer with horizontal scaling.

## Interface
- `IMG_W`, 240, source image width in pixels
- `IMG_H`, 180, source image height in rows
- `SCR_W`, 640, VGA active width
- `SCR_H`, 480, VGA active height
- `PIX_W`, 8, pixel width
- `ADDR_W`, 16, ROM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- `ROM_LAT`, 1, ROM read latency in cycles (1..3)
- `clk`  in  1  pixel clock; single clock domain
- `rst_n`  in  1  synchronous, active-low reset
- `line_start`  in  1  one-cycle pulse at the start of each VGA line
- `next_y`  in  10  VGA row to prefetch, sampled with `line_start`
- `vga_x`  in  10  current VGA column
- `rom_en`  out  1  ROM read enable
- `rom_addr`  out  ADDR_W  ROM read address
- `rom_data`  in  PIX_W  ROM data, valid ROM_LAT cycles after `rom_en`
- `bg_pixel`  out  PIX_W  scaled background pixel, registered
- `fetch_busy`  out  1  fetch in progress
- `underrun`  out  1  sticky: a `line_start` arrived before a fetch completed

## Operation
- Source row (tag) = `next_y`*IMG_H/SCR_H, integer floor; column = `vga_x`*IMG_W/SCR_W, floor. Use unsigned intermediates at least 19 bits wide.
- State per buffer: valid bit and 8-bit tag. Front buffer feeds display; back buffer receives fetches.
- FSM states:
  - IDLE
  - CALC: one cycle; register the tag, compute base = tag*IMG_W.
  - FETCH: IMG_W cycles, `rom_en`=1, `rom_addr`=base+i for i=0..IMG_W-1.
  - DRAIN: ROM_LAT cycles, completing writes.
  - Then back valid, back tag set, return to IDLE.
- Back-buffer write: index i is written with `rom_data` ROM_LAT cycles after the address was issued, using a delay pipeline on index and valid.
- On `line_start`, in this order:
  1. If FSM not in IDLE: set `underrun`, abort the fetch, clear back valid, no swap.
  2. Else if back valid: swap front/back, then clear the new back's valid.
  3. If `next_y` ≥ SCR_H: no fetch; the next swap presents an invalid buffer.
  4. Else if front valid and front tag = computed tag: skip the fetch (vertical reuse).
  5. Else go to CALC.
- Swap is a single select-bit toggle; no data copy.
- Display: `bg_pixel` = front[column] if front valid and `vga_x` < SCR_W, else 0.
- `underrun` clears only on reset.

## Timing
- Reset values:
  - `rom_en`=0, `rom_addr`=0, `bg_pixel`=0, `fetch_busy`=0, `underrun`=0.
  - Both valid bits 0, select bit 0, FSM in IDLE.
- `line_start` in cycle t with a fetch:
  - CALC at t+1.
  - First `rom_en` at t+2, last at t+1+IMG_W.
  - Last buffer write at t+1+IMG_W+ROM_LAT.
  - `fetch_busy` high t+1 through t+1+IMG_W+ROM_LAT.
  - Total 242 cycles at defaults, well inside the 800-cycle line period.
- `bg_pixel` latency: 1 cycle from `vga_x`, through the synchronous buffer read.
- A swap in cycle t is visible on `bg_pixel` from t+2.
- `line_start` coincident with the final DRAIN write: the fetch counts as incomplete, so underrun, abort, no swap.
- `rst_n` low mid-fetch: everything returns to reset values next cycle. Buffer contents are don't-care because valid bits are 0.

## Structure
- Shared package `bg_pkg`: IMG_W, IMG_H, SCR_W, SCR_H, PIX_W, FSM state encoding (IDLE, CALC, FETCH, DRAIN). The same constants serve the sprite renderer and the VGA mux.
- Sub-module `bg_line_buffer`: 2×IMG_W×PIX_W RAM, one write port and one synchronous read port, with bank-select inputs. Infers block RAM.
- The scheduler holds the FSM, counters, tag/valid registers, latency pipeline and scaling arithmetic.

## Test plan
- Reset, then `line_start` with `next_y`=0; ROM returns addr[7:0].
  - Required: `rom_addr` 0..239 on cycles t+2..t+241.
  - After the next `line_start`: `vga_x`=8 → `bg_pixel`=3; `vga_x`=639 → 239.
- `next_y` sequence 1, 2, 3 on successive lines.
  - Required: rows 1 and 2 map to tag 0, so no `rom_en` for row 2.
  - Row 3 maps to tag 1 and fetches addresses 240..479.
- Second `line_start` 100 cycles after the first.
  - Required: `underrun`=1 and stays 1, fetch restarts at CALC, front buffer unchanged.
- `next_y`=480.
  - Required: no `rom_en`; after the following swap, `bg_pixel`=0 for all `vga_x`.
- `rst_n` low at cycle t+50 of a fetch.
  - Required: `rom_en`=0, `fetch_busy`=0, `bg_pixel`=0 next cycle; no swap on the next `line_start`.
- ROM_LAT=3 variant.
  - Required: last write at t+244; data aligned, with `bg_pixel` for `vga_x`=320 equal to 120.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared background/display constants and the line-fetch FSM encoding,
// used by the scheduler, the sprite renderer and the VGA mux.
package bg_pkg;

    localparam int IMG_W = 240;
    localparam int IMG_H = 180;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/bg_line_buffer.sv
// Ping-pong pair of source-row buffers in one RAM: one write port, one
// registered read port, each with its own bank select.
module bg_line_buffer #(
    parameter int DEPTH = bg_pkg::IMG_W,
    parameter int PIX_W = bg_pkg::PIX_W,
    parameter int IDX_W = $clog2(bg_pkg::IMG_W)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PIX_W-1:0] rd_data
);
    localparam int AW = IDX_W + 1;

    logic [PIX_W-1:0] mem [2*DEPTH];
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    assign wr_addr = wr_bank ? AW'(DEPTH) + {1'b0, wr_idx} : {1'b0, wr_idx};
    assign rd_addr = rd_bank ? AW'(DEPTH) + {1'b0, rd_idx} : {1'b0, rd_idx};

    // No reset here so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bg_line_scheduler.sv
// Fetches one source row per VGA line into the back line buffer while the
// front buffer is displayed with horizontal scaling.
module bg_line_scheduler #(
    parameter int IMG_W   = bg_pkg::IMG_W,
    parameter int IMG_H   = bg_pkg::IMG_H,
    parameter int SCR_W   = bg_pkg::SCR_W,
    parameter int SCR_H   = bg_pkg::SCR_H,
    parameter int PIX_W   = bg_pkg::PIX_W,
    parameter int ADDR_W  = 16,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic [9:0]        next_y,
    input  logic [9:0]        vga_x,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [PIX_W-1:0]  bg_pixel,
    output logic              fetch_busy,
    output logic              underrun
);
    import bg_pkg::*;

    localparam int IDX_W = $clog2(IMG_W);
    localparam int TAG_W = 8;
    localparam int MUL_W = 19;
    localparam logic [9:0] SCR_W_V = 10'(SCR_W);
    localparam logic [9:0] SCR_H_V = 10'(SCR_H);

    fetch_state_t      state_reg;
    logic              sel_reg;
    logic [1:0]        valid_reg;
    logic [TAG_W-1:0]  tag_reg [2];
    logic [TAG_W-1:0]  fetch_tag_reg;
    logic              blank_pending_reg;
    logic [IDX_W-1:0]  cnt_reg;
    logic [1:0]        drain_reg;
    logic              underrun_reg;
    logic              rom_en_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic              pix_ok_reg;
    logic [ROM_LAT-1:0] pipe_vld_reg;
    logic [IDX_W-1:0]  pipe_idx_reg [ROM_LAT];

    logic [MUL_W-1:0]  row_prod;
    logic [MUL_W-1:0]  col_prod;
    logic [TAG_W-1:0]  new_tag;
    logic [IDX_W-1:0]  col_idx;
    logic              busy_now;
    logic              do_swap;
    logic              eff_front;
    logic              front_hit;
    logic [ADDR_W-1:0] base_addr;
    logic [PIX_W-1:0]  rd_data;

    always_comb begin
        row_prod  = MUL_W'(next_y) * MUL_W'(IMG_H);
        col_prod  = MUL_W'(vga_x) * MUL_W'(IMG_W);
        new_tag   = TAG_W'(row_prod / MUL_W'(SCR_H));
        col_idx   = '0;
        if (vga_x < SCR_W_V) begin
            col_idx = IDX_W'(col_prod / MUL_W'(SCR_W));
        end
        busy_now  = (state_reg != ST_IDLE);
        // An off-screen row leaves a pending blank so the next line swaps in
        // the empty buffer even though nothing was fetched into it.
        do_swap   = !busy_now && (valid_reg[~sel_reg] || blank_pending_reg);
        eff_front = sel_reg ^ do_swap;
        front_hit = valid_reg[eff_front] && (tag_reg[eff_front] == new_tag);
    end

    assign base_addr = ADDR_W'(fetch_tag_reg) * ADDR_W'(IMG_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            sel_reg           <= 1'b0;
            valid_reg         <= 2'b00;
            tag_reg[0]        <= '0;
            tag_reg[1]        <= '0;
            fetch_tag_reg     <= '0;
            blank_pending_reg <= 1'b0;
            cnt_reg           <= '0;
            drain_reg         <= '0;
            underrun_reg      <= 1'b0;
            rom_en_reg        <= 1'b0;
            rom_addr_reg      <= '0;
            pix_ok_reg        <= 1'b0;
            pipe_vld_reg      <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                pipe_idx_reg[s] <= '0;
            end
        end else begin
            pix_ok_reg      <= valid_reg[sel_reg] && (vga_x < SCR_W_V);
            pipe_vld_reg[0] <= rom_en_reg;
            pipe_idx_reg[0] <= cnt_reg;
            for (int s = 1; s < ROM_LAT; s++) begin
                pipe_vld_reg[s] <= pipe_vld_reg[s-1];
                pipe_idx_reg[s] <= pipe_idx_reg[s-1];
            end

            if (line_start) begin
                rom_en_reg <= 1'b0;
                if (busy_now) begin
                    // Late fetch: drop it, including any reads still in flight.
                    underrun_reg         <= 1'b1;
                    valid_reg[~sel_reg]  <= 1'b0;
                    pipe_vld_reg         <= '0;
                end else if (do_swap) begin
                    sel_reg              <= ~sel_reg;
                    valid_reg[sel_reg]   <= 1'b0;
                    blank_pending_reg    <= 1'b0;
                end
                if (next_y >= SCR_H_V) begin
                    state_reg         <= ST_IDLE;
                    blank_pending_reg <= 1'b1;
                end else if (front_hit) begin
                    state_reg <= ST_IDLE;
                end else begin
                    state_reg     <= ST_CALC;
                    fetch_tag_reg <= new_tag;
                end
            end else begin
                case (state_reg)
                    ST_CALC: begin
                        rom_addr_reg <= base_addr;
                        rom_en_reg   <= 1'b1;
                        cnt_reg      <= '0;
                        state_reg    <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (cnt_reg == IDX_W'(IMG_W - 1)) begin
                            rom_en_reg <= 1'b0;
                            drain_reg  <= '0;
                            state_reg  <= ST_DRAIN;
                        end else begin
                            cnt_reg      <= cnt_reg + 1'b1;
                            rom_addr_reg <= rom_addr_reg + 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_reg == 2'(ROM_LAT - 1)) begin
                            valid_reg[~sel_reg] <= 1'b1;
                            tag_reg[~sel_reg]   <= fetch_tag_reg;
                            state_reg           <= ST_IDLE;
                        end else begin
                            drain_reg <= drain_reg + 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    bg_line_buffer #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W),
        .IDX_W (IDX_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (pipe_vld_reg[ROM_LAT-1]),
        .wr_bank (~sel_reg),
        .wr_idx  (pipe_idx_reg[ROM_LAT-1]),
        .wr_data (rom_data),
        .rd_bank (sel_reg),
        .rd_idx  (col_idx),
        .rd_data (rd_data)
    );

    assign rom_en     = rom_en_reg;
    assign rom_addr   = rom_addr_reg;
    assign bg_pixel   = pix_ok_reg ? rd_data : '0;
    assign fetch_busy = busy_now;
    assign underrun   = underrun_reg;

endmodule
